// File: rtl/shift_pkg.sv
// Shared widths and FSM state type for the sequential logical-left-shift unit.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STEP_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sll_state_e;

endpackage

// File: rtl/sll_step.sv
// One shift stage: data_in << 2^k when en is set, otherwise pass-through.
module sll_step
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]   data_in,
  input  logic              en,
  input  logic [STEP_W-1:0] k,
  output logic [XLEN-1:0]   data_out_c
);

  logic [SHAMT_W:0] dist_c;

  assign dist_c     = (SHAMT_W + 1)'(1) << k;
  assign data_out_c = en ? (data_in << dist_c) : data_in;

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle logical shift left: rd_data = rs1_data << rs2_data[4:0].
// Define SLL_SEQ_LOG_STEP_EN for the fixed 5-step (2^k) mode; default is bit-serial.
module sll_seq
  import shift_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data
);

  sll_state_e         state_q, state_nxt;
  logic [XLEN-1:0]    operand_q, operand_nxt;
  logic [SHAMT_W-1:0] counter_q, counter_nxt;
  logic               in_ready_q, out_valid_q;
  logic               step_en;
  logic [STEP_W-1:0]  step_k;
  logic [XLEN-1:0]    step_out_c;
  logic               unused_rs2_hi;

  assign unused_rs2_hi = ^rs2_data[XLEN-1:SHAMT_W];

`ifdef SLL_SEQ_LOG_STEP_EN
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SHAMT_W - 1);

  logic [STEP_W-1:0] step_q, step_nxt;

  // counter_q holds the captured shamt; each step applies its bit as 2^k
  assign step_en = |(counter_q & (SHAMT_W'(1) << step_q));
  assign step_k  = step_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) step_q <= '0;
    else            step_q <= step_nxt;
  end
`else
  assign step_en = 1'b1;
  assign step_k  = '0;
`endif

  sll_step u_step (
    .data_in    (operand_q),
    .en         (step_en),
    .k          (step_k),
    .data_out_c (step_out_c)
  );

  always_comb begin
    state_nxt   = state_q;
    operand_nxt = operand_q;
    counter_nxt = counter_q;
`ifdef SLL_SEQ_LOG_STEP_EN
    step_nxt    = step_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_nxt = rs1_data;
          counter_nxt = rs2_data[SHAMT_W-1:0];
`ifdef SLL_SEQ_LOG_STEP_EN
          step_nxt    = '0;
          state_nxt   = SHIFT;
`else
          state_nxt   = (rs2_data[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
`endif
        end
      end
      SHIFT: begin
        operand_nxt = step_out_c;
`ifdef SLL_SEQ_LOG_STEP_EN
        if (step_q == STEP_LAST) begin
          step_nxt  = '0;
          state_nxt = DONE;
        end else begin
          step_nxt  = step_q + STEP_W'(1);
        end
`else
        counter_nxt = counter_q - SHAMT_W'(1);
        if (counter_q == SHAMT_W'(1)) state_nxt = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush wins over accept and the output handshake
    if (i_flush) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
`ifdef SLL_SEQ_LOG_STEP_EN
      step_nxt    = '0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      counter_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      operand_q   <= operand_nxt;
      counter_q   <= counter_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rd_data   = operand_q;

endmodule

// File: tb/tb_sll_seq.sv
// Scoreboard bench for sll_seq; build with SLL_SEQ_LOG_STEP_EN defined to cover log-step mode.
module tb_sll_seq;

  localparam int N_RAND    = 1500;
  localparam int LAT_LIMIT = 40;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  sll_seq dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_data   (rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0};
    return r;
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef SLL_SEQ_LOG_STEP_EN
    return 6;
`else
    return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
`endif
  endfunction

  // accept one op, check latency, hold the result for `hold` cycles, then hand it off
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    chk("pre_in_ready", 32'(in_ready), 32'd1);
    sb_q.push_back(ref_sll(a, b));
    in_valid = 1'b1;
    rs1_data = a;
    rs2_data = b;
    tick();
    rs1_data = $urandom;
    rs2_data = $urandom;
    lat = 1;
    while (!out_valid && lat < LAT_LIMIT) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_latency(b)));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", rd_data, sb_q[0]);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("rd_data", rd_data, sb_q.pop_front());
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_a[6];
    logic [31:0] d_b[6];
    int          d_h[6];
    int          n_acc;
    int          cyc;

    d_a = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
    d_b = '{32'h0000_001F, 32'hFFFF_FFE0, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 32'h0000_003F};
    d_h = '{0, 0, 10, 2, 0, 1};

    i_reset_n = 1'b0;
    i_flush   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rs1_data  = '0;
    rs2_data  = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    i_reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_op(d_a[i], d_b[i], d_h[i]);

    // flush in the third SHIFT cycle
    in_valid = 1'b1;
    rs1_data = 32'hFFFF_FFFF;
    rs2_data = 32'd8;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    expect_quiet("flush_no_valid", LAT_LIMIT);
    run_op(32'd3, 32'd1, 0);

    // async reset mid-SHIFT
    in_valid = 1'b1;
    rs1_data = 32'hCAFE_F00D;
    rs2_data = 32'd20;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1 i_reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    #2 i_reset_n = 1'b1;
    tick();
    expect_quiet("rst_no_stale", LAT_LIMIT);
    run_op(32'h0000_00F0, 32'd28, 1);

    // random traffic with handshake gaps; in_valid while busy must be ignored
    n_acc = 0;
    cyc   = 0;
    while ((n_acc < N_RAND || sb_q.size() != 0) && cyc < 60000) begin
      in_valid  = (n_acc < N_RAND) && ($urandom_range(3) != 0);
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      out_ready = ($urandom_range(2) != 0);
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_sll(rs1_data, rs2_data));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("rand_unexpected_out", 32'd1, 32'd0);
        else                  chk("rand_rd", rd_data, sb_q.pop_front());
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_accepted", 32'(n_acc), 32'(N_RAND));
    chk("rand_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
